// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle for one master of the RAM port arbiter.
// master = the requesting block, slave = the arbiter.
interface ram_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  valid;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ready;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output valid, write, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, write, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for RAM port A: one grant per cycle, round-robin or fixed priority,
// burst lock for requester 1, read data returned one cycle after accept.
module ram_port_arbiter #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter bit          FIXED_PRIORITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetN,
    ram_port_arbiter_if.slave     req0,
    ram_port_arbiter_if.slave     req1,
    input  logic                  req1_lock,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [15:0]           grant_cnt1
);

    logic                  gnt0;
    logic                  gnt1;
    logic                  last_q;
    logic                  lock_own_q;
    logic                  pend_valid_q;
    logic                  pend_id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [15:0]           cnt1_q;

    // Lock only counts while req1 keeps asserting it; dropping it restores normal arbitration
    // in the same cycle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (lock_own_q && req1_lock) begin
            gnt1 = req1.valid;
        end else if (FIXED_PRIORITY) begin
            gnt0 = req0.valid;
            gnt1 = req1.valid && !req0.valid;
        end else if (req0.valid && req1.valid) begin
            gnt0 = last_q;
            gnt1 = !last_q;
        end else begin
            gnt0 = req0.valid;
            gnt1 = req1.valid;
        end
    end

    assign req0.ready = gnt0;
    assign req1.ready = gnt1;

    // Idle cycles replay the last granted address/data so the RAM inputs stay quiet.
    always_comb begin
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        ram_wren  = 1'b0;
        if (gnt0) begin
            ram_addr  = req0.addr;
            ram_wdata = req0.wdata;
            ram_wren  = req0.write;
        end else if (gnt1) begin
            ram_addr  = req1.addr;
            ram_wdata = req1.wdata;
            ram_wren  = req1.write;
        end
    end

    assign req0.rvalid = pend_valid_q && !pend_id_q;
    assign req1.rvalid = pend_valid_q && pend_id_q;
    assign req0.rdata  = (pend_valid_q && !pend_id_q) ? ram_q : '0;
    assign req1.rdata  = (pend_valid_q && pend_id_q) ? ram_q : '0;
    assign grant_cnt1  = cnt1_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            last_q       <= 1'b1;
            lock_own_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_id_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt1_q       <= '0;
        end else begin
            if (gnt0 || gnt1) begin
                addr_q  <= ram_addr;
                wdata_q <= ram_wdata;
                last_q  <= gnt1;
            end
            pend_valid_q <= (gnt0 && !req0.write) || (gnt1 && !req1.write);
            pend_id_q    <= gnt1;
            if (!req1_lock) begin
                lock_own_q <= 1'b0;
            end else if (gnt1) begin
                lock_own_q <= 1'b1;
            end
            if (gnt1 && (cnt1_q != 16'hFFFF)) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench: directed cycles push expected read data, a negedge monitor pops and compares.
module tb_ram_port_arbiter;

    logic        clk;
    logic        resetN;
    logic        lock;
    logic [9:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_wren;
    logic [15:0] ram_q;
    logic [15:0] cnt1;
    logic [15:0] mem [0:1023];

    logic        flock;
    logic [9:0]  fram_addr;
    logic [15:0] fram_wdata;
    logic        fram_wren;
    logic [15:0] fq;
    logic [15:0] fcnt1;

    int vectors;
    int miscompares;
    int cyc_n;
    int cnt_model;
    bit mon_en;

    logic [15:0] ref_mem [0:1023];
    logic [15:0] q0_data [$];
    int          q0_cyc  [$];
    logic [15:0] q1_data [$];
    int          q1_cyc  [$];

    ram_port_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) r0 ();
    ram_port_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) r1 ();
    ram_port_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) f0 ();
    ram_port_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) f1 ();

    ram_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .FIXED_PRIORITY(1'b0)) dut_rr (
        .clk        (clk),
        .resetN     (resetN),
        .req0       (r0),
        .req1       (r1),
        .req1_lock  (lock),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_wren   (ram_wren),
        .ram_q      (ram_q),
        .grant_cnt1 (cnt1)
    );

    ram_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .FIXED_PRIORITY(1'b1)) dut_fp (
        .clk        (clk),
        .resetN     (resetN),
        .req0       (f0),
        .req1       (f1),
        .req1_lock  (flock),
        .ram_addr   (fram_addr),
        .ram_wdata  (fram_wdata),
        .ram_wren   (fram_wren),
        .ram_q      (fq),
        .grant_cnt1 (fcnt1)
    );

    assign flock = 1'b0;
    assign fq    = 16'h0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Port-A RAM model: registered read, new data on read-during-write.
    always @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_addr] <= ram_wdata;
            ram_q         <= ram_wdata;
        end else begin
            ram_q <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (r0.rvalid) begin
                if (q0_data.size() == 0) begin
                    chk("req0 unexpected rvalid", 1, 0);
                end else begin
                    chk("req0 rdata", r0.rdata, q0_data.pop_front());
                    chk("req0 read latency", cyc_n, q0_cyc.pop_front());
                end
            end else if (q0_cyc.size() > 0 && q0_cyc[0] <= cyc_n) begin
                chk("req0 missing rvalid", 0, 1);
                void'(q0_data.pop_front());
                void'(q0_cyc.pop_front());
            end else begin
                chk("req0 idle rdata", r0.rdata, 0);
            end
            if (r1.rvalid) begin
                if (q1_data.size() == 0) begin
                    chk("req1 unexpected rvalid", 1, 0);
                end else begin
                    chk("req1 rdata", r1.rdata, q1_data.pop_front());
                    chk("req1 read latency", cyc_n, q1_cyc.pop_front());
                end
            end else if (q1_cyc.size() > 0 && q1_cyc[0] <= cyc_n) begin
                chk("req1 missing rvalid", 0, 1);
                void'(q1_data.pop_front());
                void'(q1_cyc.pop_front());
            end else begin
                chk("req1 idle rdata", r1.rdata, 0);
            end
        end
    end

    task automatic accept(input bit id, input logic w, input logic [9:0] a, input logic [15:0] d);
        if (w) begin
            ref_mem[a] = d;
        end else if (id == 1'b0) begin
            q0_data.push_back(ref_mem[a]);
            q0_cyc.push_back(cyc_n + 1);
        end else begin
            q1_data.push_back(ref_mem[a]);
            q1_cyc.push_back(cyc_n + 1);
        end
        if (id == 1'b1 && cnt_model != 32'hFFFF) cnt_model++;
    endtask

    // Called at posedge+1; drives one cycle and checks the hand-computed grants.
    task automatic cyc(input logic v0, input logic w0, input logic [9:0] a0, input logic [15:0] d0,
                       input logic v1, input logic w1, input logic [9:0] a1, input logic [15:0] d1,
                       input logic lk, input logic e0, input logic e1);
        r0.valid = v0; r0.write = w0; r0.addr = a0; r0.wdata = d0;
        r1.valid = v1; r1.write = w1; r1.addr = a1; r1.wdata = d1;
        lock = lk;
        #3;
        chk("req0_ready", r0.ready, e0);
        chk("req1_ready", r1.ready, e1);
        if (v0 && e0) accept(1'b0, w0, a0, d0);
        if (v1 && e1) accept(1'b1, w1, a1, d1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input logic [9:0] exp_addr);
        r0.valid = 1'b0;
        r1.valid = 1'b0;
        lock     = 1'b0;
        #3;
        chk("ram_addr hold", ram_addr, exp_addr);
        chk("ram_wren idle", ram_wren, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic fp_cyc(input logic v0, input logic [9:0] a0, input logic v1,
                          input logic [9:0] a1, input logic e0, input logic e1);
        f0.valid = v0; f0.write = 1'b1; f0.addr = a0; f0.wdata = 16'h0F00;
        f1.valid = v1; f1.write = 1'b1; f1.addr = a1; f1.wdata = 16'h0F01;
        #3;
        chk("fp req0_ready", f0.ready, e0);
        chk("fp req1_ready", f1.ready, e1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        r0.valid = 1'b0; r0.write = 1'b0; r0.addr = '0; r0.wdata = '0;
        r1.valid = 1'b0; r1.write = 1'b0; r1.addr = '0; r1.wdata = '0;
        f0.valid = 1'b0; f0.write = 1'b0; f0.addr = '0; f0.wdata = '0;
        f1.valid = 1'b0; f1.write = 1'b0; f1.addr = '0; f1.wdata = '0;
        lock   = 1'b0;
        resetN = 1'b0;
        q0_data.delete(); q0_cyc.delete();
        q1_data.delete(); q1_cyc.delete();
        cnt_model = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset req0_rvalid", r0.rvalid, 0);
        chk("reset req1_rvalid", r1.rvalid, 0);
        chk("reset req0_rdata", r0.rdata, 0);
        chk("reset req1_rdata", r1.rdata, 0);
        chk("reset ram_wren", ram_wren, 0);
        chk("reset ram_addr", ram_addr, 0);
        chk("reset ram_wdata", ram_wdata, 0);
        chk("reset grant_cnt1", cnt1, 0);
        resetN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc_n       = 0;
        mon_en      = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0000;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        do_reset();
        mon_en = 1'b1;

        // Preload through requester 1, then a single read by requester 0.
        cyc(0, 0, 0, 0,        1, 1, 5, 16'hBEEF, 0, 0, 1);
        cyc(0, 0, 0, 0,        1, 1, 6, 16'h1234, 0, 0, 1);
        cyc(1, 0, 5, 0,        0, 0, 0, 0,        0, 1, 0);
        idle_chk(10'd5);

        // Round-robin: requester 0 wins the first tie after reset, then alternation.
        do_reset();
        cyc(1, 0, 5, 0,        1, 0, 6, 0,        0, 1, 0);
        cyc(1, 0, 6, 0,        1, 0, 6, 0,        0, 0, 1);
        cyc(1, 0, 6, 0,        1, 0, 5, 0,        0, 1, 0);
        cyc(1, 0, 5, 0,        1, 0, 5, 0,        0, 0, 1);
        idle_chk(10'd5);

        // Lock requested while unlocked loses the tie; lock engages on the next req1 grant.
        do_reset();
        cyc(1, 0, 6, 0,        1, 1, 0, 16'hA000, 1, 1, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 5, 0,    1, 1, 10'(i), 16'hA000 + 16'(i), 1, 0, 1);
        end
        chk("grant_cnt1 after burst", cnt1, 8);
        cyc(1, 0, 5, 0,        0, 0, 0, 0,        0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 0,    1, 0, 10'(i), 0,   0, 0, 1);
        end
        idle_chk(10'd7);
        chk("grant_cnt1 after readback", cnt1, cnt_model);

        // Reset pulled during the read-return cycle drops the pending rvalid.
        cyc(1, 0, 3, 0,        0, 0, 0, 0,        0, 1, 0);
        do_reset();
        idle_chk(10'd0);
        idle_chk(10'd0);

        // Write then read of the same address in consecutive cycles.
        cyc(1, 1, 3, 16'h00FF, 0, 0, 0, 0,        0, 1, 0);
        cyc(1, 0, 3, 0,        0, 0, 0, 0,        0, 1, 0);
        idle_chk(10'd3);
        idle_chk(10'd3);

        // Fixed-priority instance: requester 1 waits until requester 0 drops.
        for (int i = 0; i < 4; i++) begin
            fp_cyc(1, 10'(20 + i), 1, 10'd9, 1, 0);
        end
        f0.valid = 1'b0;
        #3;
        chk("fp ram_addr to req1", fram_addr, 9);
        chk("fp ram_wren", fram_wren, 1);
        fp_cyc(0, 0, 1, 10'd9, 0, 1);
        f1.valid = 1'b0;
        chk("fp grant_cnt1", fcnt1, 1);

        idle_chk(10'd3);
        chk("req0 responses drained", q0_data.size(), 0);
        chk("req1 responses drained", q1_data.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
